// File: rtl/mem_req_arbiter_if.sv
// Signal bundle around the instruction/data to shared-port arbiter.
// master = the arbiter's view; slave = the requesters plus the shared memory port.
interface mem_req_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging the fetch and load/store request ports onto one
// shared memory port, with at most one transaction outstanding at a time.
module mem_req_arbiter (
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.master mem
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [1:0] state;
    logic       owner;
    logic       last_grant;

    logic winner;
    logic fwd_valid;
    logic fwd_sel;
    logic accept;
    logic done;

    // On a tie, the requester that did not win last time goes first.
    always_comb begin
        winner = mem.data_req ? OWN_DATA : OWN_INST;
        if (mem.inst_req && mem.data_req)
            winner = ~last_grant;
    end

    // Once a request is presented but not accepted, the owner is locked in ADDR.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_sel   = owner;
        if (!reset) begin
            case (state)
                IDLE: begin
                    fwd_valid = mem.inst_req | mem.data_req;
                    fwd_sel   = winner;
                end
                ADDR:    fwd_valid = 1'b1;
                default: fwd_valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        mem.bus_req   = 1'b0;
        mem.bus_wr    = 1'b0;
        mem.bus_size  = 2'b00;
        mem.bus_wstrb = 4'b0000;
        mem.bus_addr  = 32'h0;
        mem.bus_wdata = 32'h0;
        if (fwd_valid) begin
            mem.bus_req = 1'b1;
            if (fwd_sel == OWN_DATA) begin
                mem.bus_wr    = mem.data_wr;
                mem.bus_size  = mem.data_size;
                mem.bus_wstrb = mem.data_wstrb;
                mem.bus_addr  = mem.data_addr;
                mem.bus_wdata = mem.data_wdata;
            end else begin
                mem.bus_size = 2'b10;
                mem.bus_addr = mem.inst_addr;
            end
        end
    end

    // addr_ok is only meaningful while we drive bus_req; data_ok only in WAIT.
    assign accept = fwd_valid & mem.bus_addr_ok;
    assign done   = ~reset & (state == WAIT) & mem.bus_data_ok;

    assign mem.inst_addr_ok = accept & (fwd_sel == OWN_INST);
    assign mem.data_addr_ok = accept & (fwd_sel == OWN_DATA);
    assign mem.inst_data_ok = done & (owner == OWN_INST);
    assign mem.data_data_ok = done & (owner == OWN_DATA);
    assign mem.inst_rdata   = mem.bus_rdata;
    assign mem.data_rdata   = mem.bus_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            last_grant <= OWN_INST;
        end else begin
            case (state)
                IDLE: begin
                    if (fwd_valid) begin
                        owner <= winner;
                        if (mem.bus_addr_ok) begin
                            last_grant <= winner;
                            state      <= WAIT;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (mem.bus_addr_ok) begin
                        last_grant <= owner;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.bus_data_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized and directed bench for mem_req_arbiter against a transaction-level
// model of the shared port (who holds the port, who is waiting, who won last).
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_arbiter_if bif();

    mem_req_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .mem   (bif.master)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: -1 = nobody, 0 = inst, 1 = data.
    int   m_busy;     // requester whose transaction is outstanding on the port
    int   m_lock;     // requester presented but not yet accepted
    int   m_last;     // requester accepted most recently
    logic        e_fwd;
    int          e_sel;
    logic [71:0] e_bus;
    logic        e_iaok, e_daok, e_idok, e_ddok;
    int          grants[$];

    task automatic model_reset();
        m_busy = -1;
        m_lock = -1;
        m_last = 0;
    endtask

    task automatic model_eval();
        e_fwd = 1'b0; e_sel = 0; e_bus = '0;
        e_iaok = 1'b0; e_daok = 1'b0; e_idok = 1'b0; e_ddok = 1'b0;
        if (!reset) begin
            if (m_busy >= 0) begin
                e_idok = bif.bus_data_ok && (m_busy == 0);
                e_ddok = bif.bus_data_ok && (m_busy == 1);
            end else begin
                if (m_lock >= 0) begin
                    e_fwd = 1'b1; e_sel = m_lock;
                end else if (bif.inst_req && bif.data_req) begin
                    e_fwd = 1'b1; e_sel = 1 - m_last;
                end else if (bif.inst_req || bif.data_req) begin
                    e_fwd = 1'b1; e_sel = bif.data_req ? 1 : 0;
                end
                if (e_fwd) begin
                    if (e_sel == 1)
                        e_bus = {1'b1, bif.data_wr, bif.data_size, bif.data_wstrb,
                                 bif.data_addr, bif.data_wdata};
                    else
                        e_bus = {1'b1, 1'b0, 2'b10, 4'b0000, bif.inst_addr, 32'h0};
                    e_iaok = bif.bus_addr_ok && (e_sel == 0);
                    e_daok = bif.bus_addr_ok && (e_sel == 1);
                end
            end
        end
    endtask

    task automatic model_update();
        if (reset) model_reset();
        else if (m_busy >= 0) begin
            if (bif.bus_data_ok) m_busy = -1;
        end else if (e_fwd) begin
            if (bif.bus_addr_ok) begin
                m_busy = e_sel; m_last = e_sel; m_lock = -1;
            end else begin
                m_lock = e_sel;
            end
        end
    endtask

    // Entered at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        #1;
        model_eval();
        chk("bus", {bif.bus_req, bif.bus_wr, bif.bus_size, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata}, e_bus);
        chk("ok", {bif.inst_addr_ok, bif.data_addr_ok, bif.inst_data_ok, bif.data_data_ok},
            {e_iaok, e_daok, e_idok, e_ddok});
        chk("rdata", {bif.inst_rdata, bif.data_rdata}, {2{bif.bus_rdata}});
        if (bif.inst_addr_ok) grants.push_back(0);
        if (bif.data_addr_ok) grants.push_back(1);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bif.inst_req = 0; bif.inst_addr = '0;
        bif.data_req = 0; bif.data_wr = 0; bif.data_size = '0; bif.data_wstrb = '0;
        bif.data_addr = '0; bif.data_wdata = '0;
        bif.bus_addr_ok = 0; bif.bus_data_ok = 0; bif.bus_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bit inst_pend, data_pend;
        logic [3:0] exp_order;
        reset = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);

        // Reset state, then a store accepted in the same cycle and completed 3 cycles later.
        do_reset();
        bif.data_req = 1; bif.data_wr = 1; bif.data_size = 2'b10; bif.data_wstrb = 4'b1111;
        bif.data_addr = 32'h1C00_0100; bif.data_wdata = 32'hDEAD_BEEF; bif.bus_addr_ok = 1;
        #1;
        chk("store_addr", bif.bus_addr, 32'h1C00_0100);
        chk("store_addr_ok", bif.data_addr_ok, 1'b1);
        step();
        clear_inputs();
        step();
        step();
        bif.bus_data_ok = 1; bif.bus_rdata = 32'h1234_5678;
        #1;
        chk("store_done", {bif.data_data_ok, bif.inst_data_ok}, 2'b10);
        step();

        // Reset in the middle of WAIT; the late data_ok must go nowhere.
        clear_inputs();
        bif.inst_req = 1; bif.inst_addr = 32'h0000_4000; bif.bus_addr_ok = 1;
        step();
        clear_inputs();
        step();
        reset = 1'b1; bif.bus_data_ok = 1; bif.bus_addr_ok = 1;
        #1;
        chk("rst_async", {bif.bus_req, bif.inst_addr_ok, bif.data_addr_ok, bif.inst_data_ok, bif.data_data_ok}, 5'b0);
        step();
        reset = 1'b0;
        step();
        #1;
        chk("late_data_ok", {bif.inst_data_ok, bif.data_data_ok}, 2'b00);
        step();

        // Both requesters held high after reset: data, inst, data, inst.
        do_reset();
        grants.delete();
        bif.inst_req = 1; bif.inst_addr = 32'h0000_1000;
        bif.data_req = 1; bif.data_wr = 1; bif.data_size = 2'b01; bif.data_wstrb = 4'b0011;
        bif.data_addr = 32'h0000_2000; bif.data_wdata = 32'h0000_ABCD;
        bif.bus_addr_ok = 1; bif.bus_data_ok = 1;
        repeat (8) step();
        exp_order = 4'b1010;
        chk("rr_count", grants.size(), 4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk($sformatf("rr_grant%0d", k), grants[k], exp_order[3-k]);

        // Data owner stalled by addr_ok=0 while inst_req rises.
        do_reset();
        bif.data_req = 1; bif.data_addr = 32'h8000_0040; bif.data_size = 2'b00; bif.data_wstrb = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) begin bif.inst_req = 1; bif.inst_addr = 32'h0000_0044; end
            #1;
            chk("stall_addr", bif.bus_addr, 32'h8000_0040);
            chk("stall_inst_ok", bif.inst_addr_ok, 1'b0);
            step();
        end
        bif.bus_addr_ok = 1;
        step();
        bif.data_req = 0; bif.bus_addr_ok = 0;
        step();
        // WAIT with inst pending and data_ok: no issue this cycle, inst next cycle.
        bif.bus_data_ok = 1;
        #1;
        chk("wait_no_req", bif.bus_req, 1'b0);
        step();
        bif.bus_data_ok = 0;
        #1;
        chk("inst_next", {bif.bus_req, bif.bus_addr}, {1'b1, 32'h0000_0044});
        step();

        // Randomized traffic with requesters that hold until accepted.
        do_reset();
        inst_pend = 0; data_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!inst_pend && ($urandom_range(2) == 0)) begin
                inst_pend = 1; bif.inst_addr = $urandom;
            end
            if (!data_pend && ($urandom_range(2) == 0)) begin
                data_pend = 1;
                bif.data_wr = 1'($urandom); bif.data_size = 2'($urandom_range(2));
                bif.data_wstrb = 4'($urandom); bif.data_addr = $urandom; bif.data_wdata = $urandom;
            end
            bif.inst_req = inst_pend;
            bif.data_req = data_pend;
            bif.bus_addr_ok = ($urandom_range(1) == 0);
            bif.bus_data_ok = ($urandom_range(4) < 2);
            bif.bus_rdata = $urandom;
            step();
            if (e_iaok) inst_pend = 0;
            if (e_daok) data_pend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
